// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and an
// instruction cache or stalling memory.
interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        imem_stall;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_data,
        input  imem_done,
        input  imem_stall
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_data,
        output imem_done,
        output imem_stall
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory and feeds the fetch/decode latch.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [15:0]   redirect_pc_i,
    input  logic          halt_i,
    fetch_stage_if.master imem,
    output logic [15:0]   PC_f,
    output logic [15:0]   instruction_f,
    output logic          nop_f,
    output logic          halted
);

    localparam int unsigned XLEN      = 16;
    localparam logic [XLEN-1:0] NOP_INSTR = 16'h0800;
    localparam logic [XLEN-1:0] PC_STEP   = 16'd2;

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]      state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            buf_valid, buf_valid_n;
    logic [XLEN-1:0] buf_instr, buf_instr_n;
    logic            drop, drop_n;
    logic            halt_pend, halt_pend_n;

    logic in_fetch, in_wait, in_halted;
    logic req, accept, mem_ok, deliver;

    assign in_fetch  = (state == S_FETCH);
    assign in_wait   = (state == S_WAIT);
    assign in_halted = (state == S_HALTED);

    // A halt seen in FETCH stops fetching immediately, so no request goes out.
    assign req     = in_fetch & ~buf_valid & ~rst & ~redirect_i & ~halt_i;
    assign accept  = req & ~imem.imem_stall;
    // Memory data is discarded when dropped (wrong path) or when a halt drains WAIT.
    assign mem_ok  = imem.imem_done & ~drop & ~in_halted
                   & ~(in_wait & (halt_i | halt_pend));
    assign deliver = ~rst & ~redirect_i & ~in_halted & (buf_valid | mem_ok);

    assign imem.imem_rd   = req;
    assign imem.imem_addr = pc;
    assign nop_f          = ~deliver;
    assign instruction_f  = deliver ? (buf_valid ? buf_instr : imem.imem_data) : NOP_INSTR;
    assign PC_f           = rst ? (RESET_PC + PC_STEP) : (pc + PC_STEP);
    assign halted         = in_halted & ~rst;

    // Next-state: redirect first, then delivery/consume, then FSM progress.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        buf_valid_n = buf_valid;
        buf_instr_n = buf_instr;
        drop_n      = drop;
        halt_pend_n = halt_pend;

        if (redirect_i) begin
            pc_n        = redirect_pc_i;
            buf_valid_n = 1'b0;
            halt_pend_n = 1'b0;
            if (in_wait && !imem.imem_done) begin
                drop_n = 1'b1;
            end else begin
                state_n = S_FETCH;
                drop_n  = 1'b0;
            end
        end else begin
            if (deliver) begin
                if (!stall_i) begin
                    pc_n        = pc + PC_STEP;
                    buf_valid_n = 1'b0;
                end else if (!buf_valid) begin
                    buf_valid_n = 1'b1;
                    buf_instr_n = imem.imem_data;
                end
            end

            case (state)
                S_FETCH: begin
                    if (halt_i) begin
                        state_n = S_HALTED;
                    end else if (accept && !imem.imem_done) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_done) begin
                        state_n     = (halt_i || halt_pend) ? S_HALTED : S_FETCH;
                        drop_n      = 1'b0;
                        halt_pend_n = 1'b0;
                    end else if (halt_i) begin
                        halt_pend_n = 1'b1;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            buf_instr <= NOP_INSTR;
            drop      <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            buf_valid <= buf_valid_n;
            buf_instr <= buf_instr_n;
            drop      <= drop_n;
            halt_pend <= halt_pend_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/boundary cases, then random traffic
// checked against an instruction-stream scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        halt_i;
    logic [15:0] PC_f;
    logic [15:0] instruction_f;
    logic        nop_f;
    logic        halted;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem          (imem),
        .PC_f          (PC_f),
        .instruction_f (instruction_f),
        .nop_f         (nop_f),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Program image: every address holds a distinct word.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // Memory responder: 0 = always hit, N = fixed N-cycle miss, 255 = random mix.
    int          lat_mode;
    int          cyc;
    int          lat;
    logic        pend;
    int          pend_cyc;
    logic [15:0] pend_addr;

    initial begin
        imem.imem_done = 1'b0;
        imem.imem_data = 16'h0000;
        pend = 1'b0;
        pend_cyc = 0;
        pend_addr = 16'h0000;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            imem.imem_done = 1'b0;
            imem.imem_data = 16'($urandom);
            if (rst) begin
                pend = 1'b0;
            end else if (pend && cyc == pend_cyc) begin
                imem.imem_done = 1'b1;
                imem.imem_data = mem_word(pend_addr);
                pend = 1'b0;
            end else if (imem.imem_rd && !imem.imem_stall) begin
                if (lat_mode == 255)
                    lat = (($urandom % 2) == 0) ? 0 : 1 + int'($urandom % 4);
                else
                    lat = lat_mode;
                if (lat == 0) begin
                    imem.imem_done = 1'b1;
                    imem.imem_data = mem_word(imem.imem_addr);
                end else begin
                    pend      = 1'b1;
                    pend_cyc  = cyc + lat;
                    pend_addr = imem.imem_addr;
                end
            end
        end
    end

    // Scoreboard monitor: queue front is the address of the next instruction
    // the program stream must deliver.
    logic [15:0] q[$];
    logic [15:0] head;
    int          mon_errors;
    int          mon_checks;
    int          mon_consumed;

    task automatic mchk(input string name, input logic [15:0] got, input logic [15:0] exp);
        mon_checks++;
        if (got !== exp) begin
            mon_errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    initial begin
        mon_errors = 0;
        mon_checks = 0;
        mon_consumed = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                q.push_back(16'h0000);
            end else begin
                if (redirect_i) begin
                    mchk("redirect_nop", 16'(nop_f), 16'h0001);
                    mchk("redirect_rd", 16'(imem.imem_rd), 16'h0000);
                end else if (nop_f) begin
                    mchk("bubble_instr", instruction_f, 16'h0800);
                    mchk("bubble_pcf", PC_f, q[0] + 16'd2);
                end else begin
                    mchk("deliver_pcf", PC_f, q[0] + 16'd2);
                    mchk("deliver_instr", instruction_f, mem_word(q[0]));
                    if (!stall_i) begin
                        head = q.pop_front();
                        q.push_back(head + 16'd2);
                        mon_consumed++;
                    end
                end
                if (halted)
                    mchk("halted_quiet", 16'({imem.imem_rd, nop_f}), 16'h0001);
                if (redirect_i) begin
                    q.delete();
                    q.push_back(redirect_pc_i);
                end
            end
        end
    end

    int errors;
    int checks;
    int base;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 16'h0000;
        halt_i = 1'b0;
        imem.imem_stall = 1'b0;
        lat_mode = 0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_rd", 16'(imem.imem_rd), 16'h0000);
            chk("rst_nop", 16'(nop_f), 16'h0001);
            chk("rst_instr", instruction_f, 16'h0800);
            chk("rst_pcf", PC_f, 16'h0002);
            chk("rst_halted", 16'(halted), 16'h0000);
        end
        tick();
        rst = 1'b0;

        // One instruction per cycle on hits
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hit_addr", imem.imem_addr, 16'(2 * i));
            chk("hit_pcf", PC_f, 16'(2 * i + 2));
            chk("hit_nop", 16'(nop_f), 16'h0000);
            tick();
        end

        // Three-cycle miss at 0x0010
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0010;
        lat_mode = 3;
        @(negedge clk);
        tick();
        redirect_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("miss_bubble", 16'(nop_f), 16'h0001);
            tick();
        end
        @(negedge clk);
        chk("miss_pcf", PC_f, 16'h0012);
        chk("miss_nop", 16'(nop_f), 16'h0000);
        lat_mode = 0;

        // Two-cycle stall on a hit at 0x0012
        tick();
        stall_i = 1'b1;
        @(negedge clk);
        chk("stall_pcf", PC_f, 16'h0014);
        chk("stall_nop", 16'(nop_f), 16'h0000);
        tick();
        @(negedge clk);
        chk("stall_hold_rd", 16'(imem.imem_rd), 16'h0000);
        chk("stall_hold_pcf", PC_f, 16'h0014);
        chk("stall_hold_instr", instruction_f, mem_word(16'h0012));
        tick();
        stall_i = 1'b0;
        @(negedge clk);
        chk("release_pcf", PC_f, 16'h0014);
        chk("release_nop", 16'(nop_f), 16'h0000);
        tick();
        @(negedge clk);
        chk("advance_pcf", PC_f, 16'h0016);
        chk("advance_rd", 16'(imem.imem_rd), 16'h0001);

        // Redirect to 0x0100 while a miss is outstanding
        lat_mode = 3;
        tick();
        @(negedge clk);
        chk("wait_req_rd", 16'(imem.imem_rd), 16'h0001);
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0100;
        lat_mode = 0;
        @(negedge clk);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("drop_rd", 16'(imem.imem_rd), 16'h0000);
        tick();
        @(negedge clk);
        chk("stale_nop", 16'(nop_f), 16'h0001);
        tick();
        @(negedge clk);
        chk("redir_addr", imem.imem_addr, 16'h0100);
        chk("redir_rd", 16'(imem.imem_rd), 16'h0001);
        chk("redir_pcf", PC_f, 16'h0102);

        // HALT at 0x0020, then resume at 0x0040
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0020;
        @(negedge clk);
        tick();
        redirect_i = 1'b0;
        halt_i = 1'b1;
        @(negedge clk);
        chk("halt_rd", 16'(imem.imem_rd), 16'h0000);
        tick();
        halt_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("halted_flag", 16'(halted), 16'h0001);
            chk("halted_rd", 16'(imem.imem_rd), 16'h0000);
            tick();
        end
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0040;
        @(negedge clk);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("resume_halted", 16'(halted), 16'h0000);
        chk("resume_addr", imem.imem_addr, 16'h0040);
        chk("resume_pcf", PC_f, 16'h0042);

        // PC wrap from 0xFFFE
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 16'hFFFE;
        @(negedge clk);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("wrap_addr", imem.imem_addr, 16'hFFFE);
        chk("wrap_pcf", PC_f, 16'h0000);
        tick();
        @(negedge clk);
        chk("wrap_next_addr", imem.imem_addr, 16'h0000);
        chk("wrap_next_pcf", PC_f, 16'h0002);

        // Random traffic against the scoreboard
        lat_mode = 255;
        base = mon_consumed;
        repeat (2000) begin
            tick();
            stall_i         = ($urandom % 4) == 0;
            imem.imem_stall = ($urandom % 4) == 0;
            halt_i          = ($urandom % 40) == 0;
            redirect_i      = (($urandom % 20) == 0) || (halted && (($urandom % 4) == 0));
            redirect_pc_i   = 16'($urandom);
        end
        tick();
        stall_i = 1'b0;
        imem.imem_stall = 1'b0;
        halt_i = 1'b0;
        redirect_i = 1'b0;
        @(negedge clk);
        chk("random_progress", 16'((mon_consumed - base) >= 100), 16'h0001);
        tick();

        errors += mon_errors;
        checks += mon_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
